// File: rtl/id_stage2_pkg.sv
// Shared decode constants for the ID stage: RV32I opcodes, funct fields,
// ALU operation codes and the redirect controller state encoding.
package id_stage2_pkg;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4, F3_SR  = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE = 3'd1, F3_BLT = 3'd4, F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;
    localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;

    localparam logic [5:0] ALU_NOP  = 6'd0,  ALU_ADD  = 6'd1,  ALU_SUB  = 6'd2,  ALU_SLL  = 6'd3;
    localparam logic [5:0] ALU_SLT  = 6'd4,  ALU_SLTU = 6'd5,  ALU_XOR  = 6'd6,  ALU_SRL  = 6'd7;
    localparam logic [5:0] ALU_SRA  = 6'd8,  ALU_OR   = 6'd9,  ALU_AND  = 6'd10, ALU_LUI  = 6'd11;
    localparam logic [5:0] ALU_AUIPC = 6'd12, ALU_JAL = 6'd13, ALU_JALR = 6'd14, ALU_BEQ  = 6'd15;
    localparam logic [5:0] ALU_BNE  = 6'd16, ALU_BLT  = 6'd17, ALU_BGE  = 6'd18, ALU_BLTU = 6'd19;
    localparam logic [5:0] ALU_BGEU = 6'd20, ALU_LB   = 6'd21, ALU_LH   = 6'd22, ALU_LW   = 6'd23;
    localparam logic [5:0] ALU_LBU  = 6'd24, ALU_LHU  = 6'd25, ALU_SB   = 6'd26, ALU_SH   = 6'd27;
    localparam logic [5:0] ALU_SW   = 6'd28;

    typedef enum logic {ST_RUN = 1'b0, ST_DROP = 1'b1} id_state_t;
endpackage

// File: rtl/id_fwd_mux.sv
// One operand's bypass selector: x0 reads zero, otherwise the youngest
// (lowest-index) valid writer wins over the register file.
module id_fwd_mux #(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2
) (
    input  logic [4:0]              addr,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_pending,
    input  logic [5*NUM_FWD-1:0]    fwd_wd,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata,
    output logic [XLEN-1:0]         data,
    output logic                    hazard
);
    logic [NUM_FWD-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
            assign match[gi] = fwd_valid[gi] && (fwd_wd[gi*5 +: 5] == addr) && (addr != 5'd0);
        end
    endgenerate

    // Walk oldest to youngest so the lowest matching index has the last word.
    always_comb begin
        data   = (addr == 5'd0) ? '0 : rf_data;
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            if (match[i]) begin
                data   = fwd_wdata[i*XLEN +: XLEN];
                hazard = fwd_pending[i];
            end
        end
    end
endmodule

// File: rtl/id_stage2.sv
// RV32I decode stage: operand bypass, load-use stall, in-ID branch resolution
// with a one-cycle wrong-path drop, and a registered ID/EX payload.
module id_stage2
    import id_stage2_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid_i,
    output logic                    if_ready_o,
    input  logic [XLEN-1:0]         pc_i,
    input  logic [31:0]             inst_i,
    output logic [4:0]              reg1_addr_o,
    output logic [4:0]              reg2_addr_o,
    input  logic [XLEN-1:0]         data1_i,
    input  logic [XLEN-1:0]         data2_i,
    input  logic [NUM_FWD-1:0]      fwd_valid_i,
    input  logic [NUM_FWD-1:0]      fwd_pending_i,
    input  logic [5*NUM_FWD-1:0]    fwd_wd_i,
    input  logic [XLEN*NUM_FWD-1:0] fwd_wdata_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [5:0]              aluop_o,
    output logic [XLEN-1:0]         reg1_o,
    output logic [XLEN-1:0]         reg2_o,
    output logic [XLEN-1:0]         imm_o,
    output logic [4:0]              wd_o,
    output logic                    wreg_o,
    output logic [XLEN-1:0]         pc_o,
    output logic                    illegal_o,
    output logic                    redirect_o,
    output logic [XLEN-1:0]         redirect_addr_o,
    input  logic                    flush_i,
    output logic [CNT_W-1:0]        stall_cnt_o
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign rd     = inst_i[11:7];
    assign reg1_addr_o = inst_i[19:15];
    assign reg2_addr_o = inst_i[24:20];

    logic [XLEN-1:0] op1, op2;
    logic            haz1, haz2;

    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd1 (
        .addr(reg1_addr_o), .rf_data(data1_i), .fwd_valid(fwd_valid_i),
        .fwd_pending(fwd_pending_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
        .data(op1), .hazard(haz1)
    );
    id_fwd_mux #(.XLEN(XLEN), .NUM_FWD(NUM_FWD)) u_fwd2 (
        .addr(reg2_addr_o), .rf_data(data2_i), .fwd_valid(fwd_valid_i),
        .fwd_pending(fwd_pending_i), .fwd_wd(fwd_wd_i), .fwd_wdata(fwd_wdata_i),
        .data(op2), .hazard(haz2)
    );

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm_sh, pc_plus4, jalr_sum;
    assign imm_i    = XLEN'($signed(inst_i[31:20]));
    assign imm_s    = XLEN'($signed({inst_i[31:25], inst_i[11:7]}));
    assign imm_b    = XLEN'($signed({inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}));
    assign imm_j    = XLEN'($signed({inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}));
    assign imm_u    = XLEN'($signed({inst_i[31:12], 12'b0}));
    assign imm_sh   = XLEN'(inst_i[24:20]);
    assign pc_plus4 = pc_i + XLEN'(4);
    assign jalr_sum = op1 + imm_i;

    logic [5:0]      dec_aluop;
    logic [XLEN-1:0] dec_imm, dec_reg1, dec_reg2, dec_target;
    logic            dec_wreg, dec_illegal, dec_taken, use1, use2;

    always_comb begin
        dec_aluop = ALU_NOP; dec_imm = '0; dec_reg1 = '0; dec_reg2 = '0; dec_target = '0;
        dec_wreg = 1'b0; dec_illegal = 1'b0; dec_taken = 1'b0; use1 = 1'b0; use2 = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                use1 = 1'b1; dec_reg1 = op1; dec_wreg = 1'b1; dec_imm = imm_i;
                case (funct3)
                    F3_ADD:  dec_aluop = ALU_ADD;
                    F3_SLT:  dec_aluop = ALU_SLT;
                    F3_SLTU: dec_aluop = ALU_SLTU;
                    F3_XOR:  dec_aluop = ALU_XOR;
                    F3_OR:   dec_aluop = ALU_OR;
                    F3_AND:  dec_aluop = ALU_AND;
                    F3_SLL: begin
                        dec_imm = imm_sh;
                        if (funct7 == F7_BASE) dec_aluop = ALU_SLL; else dec_illegal = 1'b1;
                    end
                    default: begin
                        dec_imm = imm_sh;
                        if (funct7 == F7_BASE)     dec_aluop = ALU_SRL;
                        else if (funct7 == F7_ALT) dec_aluop = ALU_SRA;
                        else                       dec_illegal = 1'b1;
                    end
                endcase
            end
            OPC_OP: begin
                use1 = 1'b1; use2 = 1'b1; dec_reg1 = op1; dec_reg2 = op2; dec_wreg = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}:  dec_aluop = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  dec_aluop = ALU_SUB;
                    {F7_BASE, F3_SLL}:  dec_aluop = ALU_SLL;
                    {F7_BASE, F3_SLT}:  dec_aluop = ALU_SLT;
                    {F7_BASE, F3_SLTU}: dec_aluop = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  dec_aluop = ALU_XOR;
                    {F7_BASE, F3_SR}:   dec_aluop = ALU_SRL;
                    {F7_ALT,  F3_SR}:   dec_aluop = ALU_SRA;
                    {F7_BASE, F3_OR}:   dec_aluop = ALU_OR;
                    {F7_BASE, F3_AND}:  dec_aluop = ALU_AND;
                    default:            dec_illegal = 1'b1;
                endcase
            end
            OPC_LUI:   begin dec_aluop = ALU_LUI; dec_imm = imm_u; dec_wreg = 1'b1; end
            OPC_AUIPC: begin dec_aluop = ALU_AUIPC; dec_imm = imm_u; dec_reg1 = pc_i; dec_wreg = 1'b1; end
            OPC_JAL: begin
                dec_aluop = ALU_JAL; dec_imm = imm_j; dec_reg1 = pc_plus4; dec_wreg = 1'b1;
                dec_taken = 1'b1; dec_target = pc_i + imm_j;
            end
            OPC_JALR: begin
                use1 = 1'b1; dec_aluop = ALU_JALR; dec_imm = imm_i; dec_reg1 = pc_plus4;
                dec_wreg = 1'b1; dec_taken = 1'b1; dec_target = {jalr_sum[XLEN-1:1], 1'b0};
                dec_illegal = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                use1 = 1'b1; use2 = 1'b1; dec_reg1 = op1; dec_reg2 = op2; dec_imm = imm_b;
                dec_target = pc_i + imm_b;
                case (funct3)
                    F3_BEQ:  begin dec_aluop = ALU_BEQ;  dec_taken = (op1 == op2); end
                    F3_BNE:  begin dec_aluop = ALU_BNE;  dec_taken = (op1 != op2); end
                    F3_BLT:  begin dec_aluop = ALU_BLT;  dec_taken = ($signed(op1) < $signed(op2)); end
                    F3_BGE:  begin dec_aluop = ALU_BGE;  dec_taken = ($signed(op1) >= $signed(op2)); end
                    F3_BLTU: begin dec_aluop = ALU_BLTU; dec_taken = (op1 < op2); end
                    F3_BGEU: begin dec_aluop = ALU_BGEU; dec_taken = (op1 >= op2); end
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use1 = 1'b1; dec_reg1 = op1; dec_imm = imm_i; dec_wreg = 1'b1;
                case (funct3)
                    3'd0:    dec_aluop = ALU_LB;
                    3'd1:    dec_aluop = ALU_LH;
                    3'd2:    dec_aluop = ALU_LW;
                    3'd4:    dec_aluop = ALU_LBU;
                    3'd5:    dec_aluop = ALU_LHU;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use1 = 1'b1; use2 = 1'b1; dec_reg1 = op1; dec_reg2 = op2; dec_imm = imm_s;
                case (funct3)
                    3'd0:    dec_aluop = ALU_SB;
                    3'd1:    dec_aluop = ALU_SH;
                    3'd2:    dec_aluop = ALU_SW;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
        // Illegal encodings travel as a marked no-op that reads nothing and never redirects.
        if (dec_illegal) begin
            dec_aluop = ALU_NOP; dec_imm = '0; dec_reg1 = '0; dec_reg2 = '0;
            dec_wreg = 1'b0; dec_taken = 1'b0; use1 = 1'b0; use2 = 1'b0;
        end
    end

    id_state_t state_reg, state_next;
    logic      ex_valid_reg, hazard, load;

    // Wrong-path instructions in DROP never stall; they are simply swallowed.
    assign hazard     = if_valid_i && (state_reg == ST_RUN) && ((use1 && haz1) || (use2 && haz2));
    assign if_ready_o = !hazard && (!ex_valid_reg || ex_ready_i);
    assign load       = if_valid_i && if_ready_o && (state_reg == ST_RUN) && !flush_i;
    assign ex_valid_o = ex_valid_reg;
    assign redirect_o = (state_reg == ST_DROP);

    always_comb begin
        state_next = ST_RUN;
        if (!flush_i && (state_reg == ST_RUN) && load && dec_taken)
            state_next = ST_DROP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= ST_RUN;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_reg <= 1'b0; aluop_o <= '0; reg1_o <= '0; reg2_o <= '0; imm_o <= '0;
            wd_o <= '0; wreg_o <= 1'b0; pc_o <= '0; illegal_o <= 1'b0;
            redirect_addr_o <= '0; stall_cnt_o <= '0;
        end else begin
            if (flush_i) begin
                ex_valid_reg <= 1'b0;
            end else if (ex_valid_reg && !ex_ready_i) begin
                ex_valid_reg <= 1'b1;
            end else if (load) begin
                ex_valid_reg <= 1'b1;
                aluop_o      <= dec_aluop;
                reg1_o       <= dec_reg1;
                reg2_o       <= dec_reg2;
                imm_o        <= dec_imm;
                wd_o         <= dec_wreg ? rd : 5'd0;
                wreg_o       <= dec_wreg;
                pc_o         <= pc_i;
                illegal_o    <= dec_illegal;
            end else begin
                ex_valid_reg <= 1'b0;
            end
            if (load && dec_taken)
                redirect_addr_o <= dec_target;
            if (hazard && (!ex_valid_reg || ex_ready_i) && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end
endmodule

// File: tb/tb_id_stage2.sv
// Directed bench for id_stage2: a decode vector table plus hand-written
// stall, redirect, backpressure, flush and reset sequences.
module tb_id_stage2;
    import id_stage2_pkg::*;
    localparam int XLEN = 32, NUM_FWD = 2, CNT_W = 16;

    logic              clk = 1'b0, rst = 1'b0;
    logic              if_valid = 1'b0, ex_ready = 1'b1, flush = 1'b0;
    logic [31:0]       pc = '0, inst = '0, data1 = '0, data2 = '0;
    logic [1:0]        fwd_valid = '0, fwd_pending = '0;
    logic [9:0]        fwd_wd = '0;
    logic [63:0]       fwd_wdata = '0;
    logic              if_ready, ex_valid, wreg, illegal, redirect;
    logic [4:0]        reg1_addr, reg2_addr, wd;
    logic [5:0]        aluop;
    logic [31:0]       reg1, reg2, imm, pc_out, redirect_addr;
    logic [CNT_W-1:0]  stall_cnt;

    always #5 clk = ~clk;

    id_stage2 #(.XLEN(XLEN), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .if_ready_o(if_ready),
        .pc_i(pc), .inst_i(inst), .reg1_addr_o(reg1_addr), .reg2_addr_o(reg2_addr),
        .data1_i(data1), .data2_i(data2), .fwd_valid_i(fwd_valid),
        .fwd_pending_i(fwd_pending), .fwd_wd_i(fwd_wd), .fwd_wdata_i(fwd_wdata),
        .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .aluop_o(aluop),
        .reg1_o(reg1), .reg2_o(reg2), .imm_o(imm), .wd_o(wd), .wreg_o(wreg),
        .pc_o(pc_out), .illegal_o(illegal), .redirect_o(redirect),
        .redirect_addr_o(redirect_addr), .flush_i(flush), .stall_cnt_o(stall_cnt)
    );

    int checks = 0, passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    typedef struct {
        string       name;
        logic [31:0] inst, pc, d1, d2;
        logic [1:0]  fv, fp;
        logic [9:0]  fwd;
        logic [63:0] fdata;
        logic [5:0]  aluop;
        logic [31:0] reg1, reg2, imm;
        logic [4:0]  wd;
        logic        wreg, ill, redir;
        logic [31:0] raddr;
    } vec_t;

    vec_t vecs[14];

    task automatic offer(input logic [31:0] i, input logic [31:0] p);
        if_valid = 1'b1; inst = i; pc = p;
    endtask

    task automatic go_idle();
        if_valid = 1'b0; fwd_valid = '0; fwd_pending = '0; flush = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"addi",  32'hFFB00093, 32'h0,   32'h1234,     32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_ADD,  32'h0,        32'h0,    32'hFFFFFFFB, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{"addfwd", 32'h002081B3, 32'h0,  32'h55,       32'h66,   2'b11, 2'b00, 10'h021, 64'h00000009_00000007,
                     ALU_ADD,  32'h7,        32'h66,   32'h0,        5'd3, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{"subfwd", 32'h40208233, 32'h0,  32'h11,       32'h22,   2'b11, 2'b00, 10'h049, 64'h000000AA_00000099,
                     ALU_SUB,  32'h11,       32'hAA,   32'h0,        5'd4, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[3]  = '{"srai",  32'h40335293, 32'h0,   32'hF0000000, 32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_SRA,  32'hF0000000, 32'h0,    32'h3,        5'd5, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[4]  = '{"lui",   32'hABCDE3B7, 32'h0,   32'h0,        32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_LUI,  32'h0,        32'h0,    32'hABCDE000, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[5]  = '{"auipc", 32'h00001417, 32'h200, 32'h0,        32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_AUIPC, 32'h200,     32'h0,    32'h1000,     5'd8, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[6]  = '{"lw",    32'hFFC52483, 32'h0,   32'h1000,     32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_LW,   32'h1000,     32'h0,    32'hFFFFFFFC, 5'd9, 1'b1, 1'b0, 1'b0, 32'h0};
        vecs[7]  = '{"sw",    32'h00B62423, 32'h0,   32'h2000,     32'hCAFE, 2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_SW,   32'h2000,     32'hCAFE, 32'h8,        5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8]  = '{"beq",   32'h00000863, 32'h100, 32'h5,        32'h5,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_BEQ,  32'h0,        32'h0,    32'h10,       5'd0, 1'b0, 1'b0, 1'b1, 32'h110};
        vecs[9]  = '{"blt",   32'hFE20CCE3, 32'h300, 32'hFFFFFFFF, 32'h1,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_BLT,  32'hFFFFFFFF, 32'h1,    32'hFFFFFFF8, 5'd0, 1'b0, 1'b0, 1'b1, 32'h2F8};
        vecs[10] = '{"bltu",  32'hFE20ECE3, 32'h300, 32'hFFFFFFFF, 32'h1,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_BLTU, 32'hFFFFFFFF, 32'h1,    32'hFFFFFFF8, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{"jal",   32'h001000EF, 32'h400, 32'h0,        32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_JAL,  32'h404,      32'h0,    32'h800,      5'd1, 1'b1, 1'b0, 1'b1, 32'hC00};
        vecs[12] = '{"jalr",  32'h005300E7, 32'h500, 32'h1000,     32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_JALR, 32'h504,      32'h0,    32'h5,        5'd1, 1'b1, 1'b0, 1'b1, 32'h1004};
        vecs[13] = '{"illegal", 32'h0000007F, 32'h0, 32'h0,        32'h0,    2'b00, 2'b00, 10'h000, 64'h0,
                     ALU_NOP,  32'h0,        32'h0,    32'h0,        5'd0, 1'b0, 1'b1, 1'b0, 32'h0};

        // Asynchronous reset before any clock edge.
        #1 rst = 1'b1;
        #1;
        check("rst.ex_valid", 64'(ex_valid), 64'(0));
        check("rst.redirect", 64'(redirect), 64'(0));
        check("rst.imm", 64'(imm), 64'(0));
        check("rst.stall_cnt", 64'(stall_cnt), 64'(0));
        @(negedge clk) rst = 1'b0;

        foreach (vecs[k]) begin
            @(negedge clk);
            offer(vecs[k].inst, vecs[k].pc);
            data1 = vecs[k].d1; data2 = vecs[k].d2;
            fwd_valid = vecs[k].fv; fwd_pending = vecs[k].fp;
            fwd_wd = vecs[k].fwd; fwd_wdata = vecs[k].fdata;
            #1 check({vecs[k].name, ".if_ready"}, 64'(if_ready), 64'(1));
            @(posedge clk); #1;
            check({vecs[k].name, ".ex_valid"}, 64'(ex_valid), 64'(1));
            check({vecs[k].name, ".aluop"}, 64'(aluop), 64'(vecs[k].aluop));
            check({vecs[k].name, ".reg1"}, 64'(reg1), 64'(vecs[k].reg1));
            check({vecs[k].name, ".reg2"}, 64'(reg2), 64'(vecs[k].reg2));
            check({vecs[k].name, ".imm"}, 64'(imm), 64'(vecs[k].imm));
            check({vecs[k].name, ".wd"}, 64'(wd), 64'(vecs[k].wd));
            check({vecs[k].name, ".wreg"}, 64'(wreg), 64'(vecs[k].wreg));
            check({vecs[k].name, ".illegal"}, 64'(illegal), 64'(vecs[k].ill));
            check({vecs[k].name, ".redirect"}, 64'(redirect), 64'(vecs[k].redir));
            if (vecs[k].redir)
                check({vecs[k].name, ".redirect_addr"}, 64'(redirect_addr), 64'(vecs[k].raddr));
            @(negedge clk) go_idle();
            @(posedge clk); #1;
            check({vecs[k].name, ".idle_valid"}, 64'(ex_valid), 64'(0));
        end

        // Load-use stall: x5 pending in the youngest source for three cycles.
        @(negedge clk);
        offer(32'h00528333, 32'h600);
        fwd_valid = 2'b01; fwd_pending = 2'b01; fwd_wd = 10'h005; fwd_wdata = 64'h77;
        for (int c = 1; c <= 3; c++) begin
            #1 check("haz.if_ready", 64'(if_ready), 64'(0));
            @(posedge clk); #1;
            check("haz.bubble", 64'(ex_valid), 64'(0));
            check("haz.stall_cnt", 64'(stall_cnt), 64'(c));
            @(negedge clk);
        end
        fwd_pending = 2'b00;
        #1 check("haz.release_ready", 64'(if_ready), 64'(1));
        @(posedge clk); #1;
        check("haz.valid", 64'(ex_valid), 64'(1));
        check("haz.reg1", 64'(reg1), 64'(32'h77));
        check("haz.reg2", 64'(reg2), 64'(32'h77));
        check("haz.stall_hold", 64'(stall_cnt), 64'(3));
        @(negedge clk) go_idle();

        // Taken BEQ: redirect for one cycle, wrong-path instruction swallowed.
        @(negedge clk) offer(32'h00000863, 32'h100);
        @(posedge clk); #1;
        check("redir.on", 64'(redirect), 64'(1));
        check("redir.addr", 64'(redirect_addr), 64'(32'h110));
        @(negedge clk) offer(32'hFFB00093, 32'h104);
        #1 check("redir.ready", 64'(if_ready), 64'(1));
        @(posedge clk); #1;
        check("redir.off", 64'(redirect), 64'(0));
        check("redir.discard", 64'(ex_valid), 64'(0));
        @(negedge clk) go_idle();

        // Backpressure: payload frozen while EX is not ready.
        @(negedge clk) offer(32'hFFB00093, 32'h700);
        @(posedge clk); #1;
        check("bp.accept", 64'(ex_valid), 64'(1));
        @(negedge clk);
        ex_ready = 1'b0;
        offer(32'hABCDE3B7, 32'h704);
        for (int c = 0; c < 3; c++) begin
            #1 check("bp.if_ready", 64'(if_ready), 64'(0));
            @(posedge clk); #1;
            check("bp.valid", 64'(ex_valid), 64'(1));
            check("bp.imm", 64'(imm), 64'(32'hFFFFFFFB));
            check("bp.pc", 64'(pc_out), 64'(32'h700));
            @(negedge clk);
        end
        ex_ready = 1'b1;
        @(posedge clk); #1;
        check("bp.next_imm", 64'(imm), 64'(32'hABCDE000));
        check("bp.next_aluop", 64'(aluop), 64'(ALU_LUI));
        @(negedge clk) go_idle();
        @(posedge clk);

        // Flush with a taken branch offered: nothing loads, no redirect.
        @(negedge clk);
        offer(32'h00000863, 32'h100);
        flush = 1'b1;
        @(posedge clk); #1;
        check("flush.redirect", 64'(redirect), 64'(0));
        check("flush.valid", 64'(ex_valid), 64'(0));
        @(negedge clk) go_idle();

        // Reset mid-stream clears outputs without a clock edge.
        @(negedge clk) offer(32'hFFB00093, 32'h800);
        @(posedge clk); #1;
        check("mrst.pre_valid", 64'(ex_valid), 64'(1));
        #1 rst = 1'b1;
        #1;
        check("mrst.valid", 64'(ex_valid), 64'(0));
        check("mrst.imm", 64'(imm), 64'(0));
        check("mrst.wd", 64'(wd), 64'(0));
        check("mrst.wreg", 64'(wreg), 64'(0));
        check("mrst.stall_cnt", 64'(stall_cnt), 64'(0));
        @(posedge clk); #1;
        check("mrst.held", 64'(ex_valid), 64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        check("mrst.first_accept", 64'(ex_valid), 64'(1));
        check("mrst.first_imm", 64'(imm), 64'(32'hFFFFFFFB));
        @(negedge clk) go_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/id_stage2.md
ID_STAGE2 -- requirements
Module: id_stage2

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath and PC width.
REQ-002 SHALL provide parameter NUM_FWD, default 2, number of forwarding sources; index 0 is youngest.
REQ-003 SHALL provide parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL provide ports clk input 1 (clock) and rst input 1 (reset); one clock, reset asynchronous and active-high.
REQ-005 SHALL provide ports if_valid_i input 1, if_ready_o output 1, pc_i input XLEN, inst_i input 32: fetch handshake; pc_i is the instruction's own address.
REQ-006 SHALL provide ports reg1_addr_o output 5, reg2_addr_o output 5, data1_i input XLEN, data2_i input XLEN: combinational register-file read.
REQ-007 SHALL provide ports fwd_valid_i input NUM_FWD, fwd_pending_i input NUM_FWD, fwd_wd_i input 5*NUM_FWD, fwd_wdata_i input XLEN*NUM_FWD: per-source write-enable, data-not-ready (load in flight), destination, data.
REQ-008 SHALL provide ports ex_valid_o output 1, ex_ready_i input 1, aluop_o output 6, reg1_o output XLEN, reg2_o output XLEN, imm_o output XLEN, wd_o output 5, wreg_o output 1, pc_o output XLEN, illegal_o output 1: registered ID/EX payload.
REQ-009 SHALL provide ports redirect_o output 1, redirect_addr_o output XLEN: branch/jump redirect to fetch.
REQ-010 SHALL provide ports flush_i input 1 and stall_cnt_o output CNT_W.

Function
REQ-011 SHALL decode RV32I OP-IMM, OP, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE into existing aluop codes; any other encoding sets illegal_o=1, wreg_o=0, aluop_o=0.
REQ-012 SHALL sign-extend I/S/B/J immediates and zero-fill U immediates to XLEN; shift immediates take inst_i[24:20] only.
REQ-013 SHALL resolve each operand as: addr 0 -> 0; else lowest-index matching fwd_valid_i source; else register file.
REQ-014 SHALL declare a hazard when a read operand matches a valid source with fwd_pending_i=1 and no lower-index valid match.
REQ-015 SHALL drive if_ready_o = !hazard && (!ex_valid_o || ex_ready_i), combinationally.
REQ-016 SHALL load the output register on if_valid_i && if_ready_o; latency one cycle to ex_valid_o.
REQ-017 SHALL, while ex_valid_o && !ex_ready_i, hold every ex_* payload output stable.
REQ-018 SHALL, on hazard with EX ready, insert a bubble (ex_valid_o=0 next cycle) and increment stall_cnt_o, saturating at all-ones.
REQ-019 SHALL resolve branches in ID with signed compares for BLT/BGE and unsigned for BLTU/BGEU; JAL/JALR always taken; JALR target LSB cleared.
REQ-020 SHALL, on acceptance of a taken instruction, assert redirect_o for exactly the next cycle with redirect_addr_o = target; JAL/JALR write pc_i+4 to rd via reg1_o.
REQ-021 SHALL, in the redirect cycle, accept and discard any if_valid_i instruction (wrong path) without loading the output register.
REQ-022 SHALL, on flush_i, clear ex_valid_o and redirect_o next cycle and discard the instruction offered that cycle; flush_i wins over simultaneous acceptance.
REQ-023 SHALL implement the two-state controller RUN/DROP: RUN->DROP on taken acceptance, DROP->RUN unconditionally after one cycle; flush_i forces RUN.

Reset
REQ-024 SHALL on rst drive ex_valid_o, redirect_o, illegal_o, wreg_o to 0, all payload buses and stall_cnt_o to 0, state RUN, immediately and asynchronously.
REQ-025 SHALL on rst during an accepted transfer discard that transfer; first acceptance is possible the first clk edge after rst deasserts.

Structure
REQ-026 SHALL take opcode, funct3/funct7 and aluop encodings from the shared defines file; new constants (state encoding) are added there.
REQ-027 SHALL instantiate sub-module id_fwd_mux twice (one per operand), parametrised by XLEN and NUM_FWD, returning data and hazard flag.

Verification
REQ-028 SHALL cover: ADDI x1,x0,-5 accepted -> next cycle ex_valid_o=1, reg1_o=0, imm_o=32'hFFFFFFFB, wd_o=1, wreg_o=1.
REQ-029 SHALL cover: ADD x3,x1,x2 with fwd0 wd=1 data=7 and fwd1 wd=1 data=9, both valid -> reg1_o=7.
REQ-030 SHALL cover: LW pending on x5 (fwd_pending_i[0]=1), ADD x6,x5,x5 offered -> if_ready_o=0, bubble, stall_cnt_o +1 per cycle until pending drops.
REQ-031 SHALL cover: BEQ x0,x0,+16 at pc 0x100 -> redirect_o=1 one cycle, addr 0x110; instruction offered that cycle discarded.
REQ-032 SHALL cover: ex_ready_i=0 for 3 cycles with ex_valid_o=1 -> payload unchanged, if_ready_o=0; opcode 7'h7F -> illegal_o=1.
REQ-033 SHALL cover: rst asserted mid-stream -> all outputs 0 without a clk edge; flush_i with taken branch accepted -> no redirect_o.
